// File: rtl/voice_sample_fetcher.sv
// Requester side of the voice sample handshake with a small FIFO towards the codec.
// Define FETCH_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.

module voice_sample_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play,
    output logic                        generate_next,
    input  logic                        sample_ready,
    input  logic [15:0]                 sample,
    input  logic                        codec_ready,
    output logic [15:0]                 codec_sample,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        timeout_err,
    input  logic                        clear_err
`ifdef FETCH_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                  underrun_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [7:0]    tmo_cnt_r;
    logic [15:0]   last_sample_r;
    logic [15:0]   push_data_s;
    logic [15:0]   codec_sample_r;
    logic [15:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          gen_r;
    logic          err_r;
    logic          push_s;
    logic          pop_s;
    logic          timeout_s;

    assign pop_s         = codec_ready && (count_r != {CW{1'b0}});
    assign generate_next = gen_r;
    assign codec_sample  = codec_sample_r;
    assign fifo_count    = count_r;
    assign timeout_err   = err_r;

    // Next-state decode and push request for the request/wait handshake
    always_comb begin
        next_state_s = state_r;
        push_s       = 1'b0;
        push_data_s  = last_sample_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Any push lands before re-entering IDLE, so nothing is pending here
                if (play && (count_r < CW'(FIFO_DEPTH))) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (sample_ready) begin
                    push_s       = 1'b1;
                    push_data_s  = sample;
                    next_state_s = ST_IDLE;
                end else if (tmo_cnt_r == 8'(TIMEOUT - 1)) begin
                    push_s       = 1'b1;
                    push_data_s  = last_sample_r;
                    timeout_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, request pulse, wait counter, last sample and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            gen_r         <= 1'b0;
            tmo_cnt_r     <= 8'd0;
            last_sample_r <= 16'd0;
            err_r         <= 1'b0;
        end else begin
            state_r <= next_state_s;
            gen_r   <= (next_state_s == ST_REQ);
            if (state_r == ST_REQ) begin
                tmo_cnt_r <= 8'd0;
            end else if ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if ((state_r == ST_WAIT) && sample_ready) begin
                last_sample_r <= sample;
            end else begin
                last_sample_r <= last_sample_r;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else if (clear_err) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Sample FIFO: storage, pointers, occupancy and registered codec output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 16'd0;
            end
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            count_r        <= {CW{1'b0}};
            codec_sample_r <= 16'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                codec_sample_r <= mem_r[rd_ptr_r];
                rd_ptr_r       <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FETCH_UNDERRUN_CNT_EN
    logic [7:0] underrun_r;

    assign underrun_cnt = underrun_r;

    // Saturating count of codec pops that found the FIFO empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_r <= 8'd0;
        end else if (clear_err) begin
            underrun_r <= 8'd0;
        end else if (codec_ready && (count_r == {CW{1'b0}}) && (underrun_r != 8'd255)) begin
            underrun_r <= underrun_r + 8'd1;
        end else begin
            underrun_r <= underrun_r;
        end
    end
`endif

endmodule

// File: tb/tb_voice_sample_fetcher.sv
// Self-checking bench for voice_sample_fetcher: a behavioural voice drives the
// handshake and a queue-based model predicts FIFO contents, codec output and errors.

module tb_voice_sample_fetcher;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 255;

    logic        clk;
    logic        reset;
    logic        play;
    logic        generate_next;
    logic        sample_ready;
    logic [15:0] sample;
    logic        codec_ready;
    logic [15:0] codec_sample;
    logic [2:0]  fifo_count;
    logic        timeout_err;
    logic        clear_err;
`ifdef FETCH_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    voice_sample_fetcher #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .generate_next(generate_next),
        .sample_ready (sample_ready),
        .sample       (sample),
        .codec_ready  (codec_ready),
        .codec_sample (codec_sample),
        .fifo_count   (fifo_count),
        .timeout_err  (timeout_err),
        .clear_err    (clear_err)
`ifdef FETCH_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural voice: answers voice_delay cycles after each request (0 = silent)
    int          voice_delay = 0;
    int          voice_cnt   = 0;
    logic [15:0] last_voice  = 16'd0;
    initial begin
        sample_ready = 1'b0;
        sample       = 16'd0;
        forever begin
            @(posedge clk);
            #1;
            sample_ready = 1'b0;
            if (voice_cnt != 0) begin
                voice_cnt--;
                if (voice_cnt == 0) begin
                    sample       = 16'($urandom);
                    last_voice   = sample;
                    sample_ready = 1'b1;
                end
            end
            if (generate_next && voice_delay != 0) voice_cnt = voice_delay;
        end
    end

    // Reference model: what the codec sees, built from the handshake rules
    logic [15:0] mq[$];
    bit          m_out;
    int          m_wait;
    logic [15:0] m_last;
    logic [15:0] m_codec;
    bit          m_err;
    int          m_under;
    int          pulse_cnt = 0;
    always @(posedge clk) begin
        bit was_empty;
        bit tmo;
        if (reset) begin
            mq.delete();
            m_out = 0; m_wait = 0; m_last = 16'd0; m_codec = 16'd0;
            m_err = 0; m_under = 0;
        end else begin
            was_empty = (mq.size() == 0);
            tmo = 0;
            if (codec_ready && !was_empty) m_codec = mq.pop_front();
            if (m_out) begin
                if (sample_ready) begin
                    mq.push_back(sample);
                    m_last = sample;
                    m_out  = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        mq.push_back(m_last);
                        tmo   = 1;
                        m_out = 0;
                    end
                end
            end
            if (tmo) m_err = 1;
            else if (clear_err) m_err = 0;
            if (clear_err) m_under = 0;
            else if (codec_ready && was_empty && m_under < 255) m_under++;
            if (generate_next) begin
                m_out = 1; m_wait = 0; pulse_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gen(input int budget, output bit seen);
        int k = 0;
        while (generate_next !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        seen = (generate_next === 1'b1);
    endtask

    task automatic drain();
        play = 1'b0;
        step(8);
        for (int g = 0; g < 16 && mq.size() > 0; g++) begin
            codec_ready = 1'b1;
            step(1);
        end
        codec_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b0; codec_ready = 1'b0; clear_err = 1'b0;
        step(3);
        n_cmp += 4;
        if (generate_next !== 1'b0) begin n_fail++; $display("FAIL reset_gen: actual=%b required=0", generate_next); end
        if (codec_sample !== 16'd0) begin n_fail++; $display("FAIL reset_codec: actual=%h required=0", codec_sample); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: actual=%0d required=0", fifo_count); end
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: actual=%b required=0", timeout_err); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_fill();
        pulse_cnt = 0; voice_delay = 2; play = 1'b1;
        step(40);
        n_cmp += 4;
        if (pulse_cnt != 4) begin n_fail++; $display("FAIL fill_pulses: actual=%0d required=4", pulse_cnt); end
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: actual=%0d required=4", fifo_count); end
        if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL fill_model: actual=%0d required=%0d", fifo_count, mq.size()); end
        if (generate_next !== 1'b0) begin n_fail++; $display("FAIL fill_gen_idle: actual=%b required=0", generate_next); end
        step(10);
        n_cmp++;
        if (pulse_cnt != 4) begin n_fail++; $display("FAIL fill_no_more: actual=%0d required=4", pulse_cnt); end
    endtask

    task automatic test_pop_refill();
        logic [15:0] first;
        first = mq[0];
        pulse_cnt = 0;
        codec_ready = 1'b1;
        step(1);
        codec_ready = 1'b0;
        n_cmp += 2;
        if (codec_sample !== first) begin n_fail++; $display("FAIL pop_head: actual=%h required=%h", codec_sample, first); end
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_count: actual=%0d required=3", fifo_count); end
        step(20);
        n_cmp += 2;
        if (pulse_cnt != 1) begin n_fail++; $display("FAIL refill_pulses: actual=%0d required=1", pulse_cnt); end
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL refill_count: actual=%0d required=4", fifo_count); end
    endtask

    task automatic test_timeout();
        bit seen;
        voice_delay = 0;
        codec_ready = 1'b1;
        step(1);
        codec_ready = 1'b0;
        wait_gen(10, seen);
        play = 1'b0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL tmo_req: actual=0 required=1"); end
        step(255);
        n_cmp += 2;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: actual=%b required=0", timeout_err); end
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL tmo_early_count: actual=%0d required=3", fifo_count); end
        step(1);
        n_cmp += 2;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: actual=%b required=1", timeout_err); end
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL tmo_count: actual=%0d required=4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            codec_ready = 1'b1;
            step(1);
            n_cmp++;
            if (codec_sample !== m_codec) begin n_fail++; $display("FAIL tmo_pop%0d: actual=%h required=%h", i, codec_sample, m_codec); end
        end
        codec_ready = 1'b0;
        n_cmp++;
        if (codec_sample !== last_voice) begin n_fail++; $display("FAIL tmo_repeat_last: actual=%h required=%h", codec_sample, last_voice); end
        clear_err = 1'b1;
        step(1);
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL clear_err: actual=%b required=0", timeout_err); end
        play = 1'b1;
        wait_gen(10, seen);
        play = 1'b0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL tmo2_req: actual=0 required=1"); end
        step(256);
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_beats_clear: actual=%b required=1", timeout_err); end
        step(1);
        clear_err = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL clear_after: actual=%b required=0", timeout_err); end
    endtask

    task automatic test_push_pop_wrap();
        bit found = 0;
        drain();
        voice_delay = 2; play = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            if (sample_ready === 1'b1 && fifo_count === 3'd2) found = 1;
            else step(1);
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL pp_setup: actual=0 required=1"); end
        codec_ready = 1'b1;
        step(1);
        codec_ready = 1'b0;
        n_cmp += 2;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL pp_count: actual=%0d required=2", fifo_count); end
        if (codec_sample !== m_codec) begin n_fail++; $display("FAIL pp_data: actual=%h required=%h", codec_sample, m_codec); end
        play = 1'b0;
        step(8);
        for (int g = 0; g < 8 && mq.size() > 0; g++) begin
            codec_ready = 1'b1;
            step(1);
            n_cmp++;
            if (codec_sample !== m_codec) begin n_fail++; $display("FAIL wrap_order%0d: actual=%h required=%h", g, codec_sample, m_codec); end
        end
        codec_ready = 1'b0;
    endtask

    task automatic test_underrun();
        logic [15:0] held;
        held = codec_sample;
        codec_ready = 1'b1;
        step(5);
        codec_ready = 1'b0;
        n_cmp += 2;
        if (codec_sample !== held) begin n_fail++; $display("FAIL empty_hold: actual=%h required=%h", codec_sample, held); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL empty_count: actual=%0d required=0", fifo_count); end
`ifdef FETCH_UNDERRUN_CNT_EN
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        n_cmp++;
        if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL under_clear: actual=%0d required=0", underrun_cnt); end
        codec_ready = 1'b1;
        step(300);
        codec_ready = 1'b0;
        n_cmp += 2;
        if (underrun_cnt !== 8'd255) begin n_fail++; $display("FAIL under_sat: actual=%0d required=255", underrun_cnt); end
        if (underrun_cnt !== 8'(m_under)) begin n_fail++; $display("FAIL under_model: actual=%0d required=%0d", underrun_cnt, m_under); end
`endif
    endtask

    task automatic test_play_stop();
        bit seen;
        voice_delay = 3; pulse_cnt = 0; play = 1'b1;
        wait_gen(10, seen);
        play = 1'b0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL stop_req: actual=0 required=1"); end
        step(10);
        n_cmp += 2;
        if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL stop_push: actual=%0d required=1", fifo_count); end
        if (pulse_cnt != 1) begin n_fail++; $display("FAIL stop_pulses: actual=%0d required=1", pulse_cnt); end
        step(20);
        n_cmp++;
        if (pulse_cnt != 1) begin n_fail++; $display("FAIL stop_no_more: actual=%0d required=1", pulse_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        voice_delay = 2; play = 1'b1;
        wait_gen(10, seen);
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL rst_req: actual=0 required=1"); end
        step(1);
        reset = 1'b1; play = 1'b0;
        #2;
        n_cmp += 4;
        if (generate_next !== 1'b0) begin n_fail++; $display("FAIL rst_gen: actual=%b required=0", generate_next); end
        if (codec_sample !== 16'd0) begin n_fail++; $display("FAIL rst_codec: actual=%h required=0", codec_sample); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: actual=%0d required=0", fifo_count); end
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: actual=%b required=0", timeout_err); end
        step(1);
        #2;
        reset = 1'b0;
        step(3);
        n_cmp += 2;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_no_push: actual=%0d required=0", fifo_count); end
        if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rst_model: actual=%0d required=%0d", fifo_count, mq.size()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            play        = ($urandom_range(0, 3) != 0);
            codec_ready = $urandom_range(0, 1);
            voice_delay = $urandom_range(1, 4);
            step(1);
            n_cmp += 3;
            if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: actual=%0d required=%0d", c, fifo_count, mq.size()); end
            if (codec_sample !== m_codec) begin n_fail++; $display("FAIL rnd_codec@%0d: actual=%h required=%h", c, codec_sample, m_codec); end
            if (timeout_err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: actual=%b required=%b", c, timeout_err, m_err); end
        end
        codec_ready = 1'b0;
        play = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_refill();
        test_timeout();
        test_push_pop_wrap();
        test_underrun();
        test_play_stop();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
